// File: rtl/uart_word_arbiter_if.sv
// Requester and UART-side signals of uart_word_arbiter, bundled so the
// arbiter, the chaotic-map generators and the uart_core hookup share one view.
//
// Handshake semantics:
//   requester k: req[k] is a valid flag. req[k] and req_data[32k+31:32k] stay
//   stable until ack[k] pulses for one cycle. The ack pulse is the only
//   acceptance event. Dropping req before the word is latched withdraws it.
//   uart_core: uart_soc is a level that is held high with uart_databus stable
//   until uart_eoc is seen high. uart_eoc must fall again before the next word
//   is started.
interface uart_word_arbiter_if #(
   parameter int N = 4
);
   logic [N-1:0]    req;
   logic [N*32-1:0] req_data;
   logic [N-1:0]    ack;
   logic            uart_soc;
   logic [31:0]     uart_databus;
   logic            uart_eoc;

   // Arbiter side.
   modport master (
      input  req, req_data, uart_eoc,
      output ack, uart_soc, uart_databus
   );

   // Requester/UART side.
   modport slave (
      output req, req_data, uart_eoc,
      input  ack, uart_soc, uart_databus
   );
endinterface

// File: rtl/uart_word_arbiter.sv
// Round-robin sharing of one 32-bit word UART transmitter between N sample
// generators. The arbiter grants one request, drives the soc/eoc handshake and
// acks the requester when its word is done. It can stop after MAX_WORDS words.
// It abandons a word whose eoc never arrives and then flags timeout_err.
module uart_word_arbiter #(
   parameter int N           = 4,
   parameter int MAX_WORDS   = 100,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_word_arbiter_if.master    bus,
   input  logic                   enable,
   input  logic                   clear_done,
   output logic [$clog2(N)-1:0]   grant_idx,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic [15:0]            word_count,
   output logic [2:0]             state_dbg
);
   localparam int IW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEND     = 3'd1,
      WAIT_EOC = 3'd2,
      GAP      = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [TW-1:0] tmo_cnt;

   logic [IW-1:0] sel_idx;
   logic          sel_found;
   logic [31:0]   sel_data;
   logic [IW:0]   cand;
   logic [IW-1:0] next_ptr;

   assign state_dbg = state;

   // Pick the first asserted request at or above rr_ptr, wrapping at N.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!sel_found && bus.req[cand[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IW-1:0];
         end
      end
      sel_data = bus.req_data[32*sel_idx +: 32];
   end

   // The pointer moves past the granted index whether the word completed or timed out.
   always_comb begin
      next_ptr = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
   end

   // Arbitration FSM. All outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         tmo_cnt          <= '0;
         grant_idx        <= '0;
         bus.ack          <= '0;
         bus.uart_soc     <= 1'b0;
         bus.uart_databus <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         timeout_err      <= 1'b0;
         word_count       <= '0;
      end else begin
         bus.ack <= '0;
         case (state)
            IDLE: begin
               if (enable && sel_found) begin
                  grant_idx        <= sel_idx;
                  bus.uart_databus <= sel_data;
                  busy             <= 1'b1;
                  state            <= SEND;
               end
            end
            SEND: begin
               bus.uart_soc <= 1'b1;
               tmo_cnt      <= '0;
               state        <= WAIT_EOC;
            end
            WAIT_EOC: begin
               if (bus.uart_eoc) begin
                  bus.uart_soc       <= 1'b0;
                  bus.ack[grant_idx] <= 1'b1;
                  if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
                  rr_ptr             <= next_ptr;
                  state              <= GAP;
               end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  bus.uart_soc <= 1'b0;
                  timeout_err  <= 1'b1;
                  rr_ptr       <= next_ptr;
                  state        <= GAP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GAP: begin
               // A stale eoc from the previous word must clear before a new grant.
               if (!bus.uart_eoc) begin
                  busy <= 1'b0;
                  if (MAX_WORDS != 0 && word_count == 16'(MAX_WORDS)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DONE: begin
               if (clear_done) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (clear_done) begin
            word_count  <= '0;
            timeout_err <= 1'b0;
         end
      end
   end
endmodule
